// File: rtl/pc_fetch.sv
// Purpose : architectural PC/EPC registers and IDLE/FETCH/EXEC instruction-fetch sequencer.
// Latency : 2 cycles per instruction with zero-wait memory (1 FETCH + 1 EXEC); +1 per wait or stall cycle.
// Backpr. : holds o_imem_req/o_imem_addr stable until i_imem_ack; i_stall freezes EXEC (PC, EPC, instr).
//
// Ports:
//   i_clk, i_rst_n          clock (rising edge), asynchronous active-low reset
//   i_nextpc, i_pcsrc       next-PC target and select (00 seq, 01 target, 10 eret, 11 exception)
//   i_stall                 hold the current instruction in EXEC
//   o_imem_req, o_imem_addr fetch request and address (address equals o_pc)
//   i_imem_ack, i_imem_data fetch acknowledge and instruction word
//   o_pc, o_pc_plus4        current instruction address and its successor
//   o_instr, o_instr_valid  latched instruction, valid while in EXEC
//   o_epc                   exception program counter
module pc_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_nextpc,
    input  logic [1:0]  i_pcsrc,
    input  logic        i_stall,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_data,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_instr,
    output logic        o_instr_valid,
    output logic [31:0] o_epc
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_e;

    // Word alignment is enforced on every PC source so o_pc[1:0] is always 00.
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_PC_A = RESET_PC & ALIGN_MASK;
    localparam logic [31:0] EXC_VEC_A  = EXC_VECTOR & ALIGN_MASK;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4;

    // Wraps modulo 2^32 by construction of the 32-bit add.
    assign pc_plus4 = pc_q + 32'd4;

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC_A;
            epc_q   <= 32'h0000_0000;
            instr_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            instr_q <= instr_d;
        end
    end

    // Next-state and register update logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        instr_d = instr_q;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                // Ack is only meaningful here; data is captured on the handshake edge.
                if (i_imem_ack) begin
                    instr_d = i_imem_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // A stalled EXEC ignores i_pcsrc entirely so nothing architectural moves.
                if (!i_stall) begin
                    state_d = S_FETCH;
                    unique case (i_pcsrc)
                        2'b00: pc_d = pc_plus4;
                        2'b01: pc_d = i_nextpc & ALIGN_MASK;
                        2'b10: pc_d = epc_q;
                        2'b11: begin
                            epc_d = pc_q;
                            pc_d  = EXC_VEC_A;
                        end
                        default: pc_d = pc_plus4;
                    endcase
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from state/registers only: no path from ack or pcsrc.
    always_comb begin
        o_imem_req    = (state_q == S_FETCH);
        o_instr_valid = (state_q == S_EXEC);
        o_imem_addr   = pc_q;
        o_pc          = pc_q;
        o_pc_plus4    = pc_plus4;
        o_instr       = instr_q;
        o_epc         = epc_q;
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Purpose : self-checking bench for pc_fetch; scoreboard of expected fetch addresses.
// Latency : samples 1 time unit after each rising edge, drives inputs at the same point.
// Backpr. : memory model acks after a programmable number of wait cycles.
module tb_pc_fetch;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_0180;
    // Instruction memory model: word = address xor a constant.
    localparam logic [31:0] KEY        = 32'h5A5A_C3C3;
    localparam int          FETCH_TMO  = 20;

    logic        clk;
    logic        rst_n;
    logic [31:0] nextpc;
    logic [1:0]  pcsrc;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] epc;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr;

    pc_fetch #(
        .RESET_PC  (RESET_PC),
        .EXC_VECTOR(EXC_VECTOR)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_nextpc     (nextpc),
        .i_pcsrc      (pcsrc),
        .i_stall      (stall),
        .o_imem_req   (imem_req),
        .o_imem_addr  (imem_addr),
        .i_imem_ack   (imem_ack),
        .i_imem_data  (imem_data),
        .o_pc         (pc),
        .o_pc_plus4   (pc_plus4),
        .o_instr      (instr),
        .o_instr_valid(instr_valid),
        .o_epc        (epc)
    );

    assign imem_data = imem_addr ^ KEY;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one EXEC edge, then return select/stall to neutral values.
    task automatic exec_step(input logic [1:0] src, input logic [31:0] np, input logic st);
        pcsrc  = src;
        nextpc = np;
        stall  = st;
        tick();
        pcsrc  = 2'b00;
        nextpc = 32'h0;
        stall  = 1'b0;
    endtask

    // Wait (bounded) for a request, hold ack low for 'waits' cycles, then complete it.
    task automatic run_fetch(input int waits, output logic [31:0] addr,
                             output logic stable, output logic ok);
        int n = 0;
        imem_ack = 1'b0;
        ok       = 1'b1;
        stable   = 1'b1;
        addr     = 32'hx;
        while (!imem_req && n < FETCH_TMO) begin
            tick();
            n++;
        end
        if (!imem_req) begin
            ok = 1'b0;
            return;
        end
        addr = imem_addr;
        for (int i = 0; i < waits; i++) begin
            tick();
            if (!imem_req || imem_addr !== addr || instr_valid) stable = 1'b0;
        end
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        nextpc   = 32'h0;
        pcsrc    = 2'b00;
        stall    = 1'b0;
        imem_ack = 1'b0;
        repeat (2) tick();
        checks++;
        if (pc !== RESET_PC || pc_plus4 !== RESET_PC + 32'd4 || epc !== 32'h0 ||
            instr !== 32'h0 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_values pc=%h pc4=%h epc=%h instr=%h vld=%b req=%b", pc, pc_plus4, epc, instr, instr_valid, imem_req);
        end
        // Release: this cycle is cycle 0 (IDLE).
        rst_n    = 1'b1;
        imem_ack = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_cycle0 req=%b expected 0", imem_req);
        end
        for (int c = 1; c <= 6; c++) begin
            tick();
            checks++;
            if (imem_req !== (c % 2 == 1) || instr_valid !== (c % 2 == 0)) begin
                errors++;
                $display("FAIL zw_cycle%0d req=%b vld=%b expected req=%b vld=%b", c, imem_req, instr_valid, (c % 2 == 1), (c % 2 == 0));
            end
            if (imem_req) begin
                exp_addr = exp_q.pop_front();
                checks++;
                if (imem_addr !== exp_addr) begin
                    errors++;
                    $display("FAIL zw_addr cycle%0d got=%h expected=%h", c, imem_addr, exp_addr);
                end
            end
            if (instr_valid) begin
                checks++;
                if (instr !== (exp_addr ^ KEY)) begin
                    errors++;
                    $display("FAIL zw_instr cycle%0d got=%h expected=%h", c, instr, exp_addr ^ KEY);
                end
            end
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_wait_stall();
        logic [31:0] a;
        logic        st, ok;
        exp_q.push_back(32'h0000_000C);
        run_fetch(3, a, st, ok);
        exp_addr = exp_q.pop_front();
        checks++;
        if (!ok || a !== exp_addr || !st) begin
            errors++;
            $display("FAIL wait_fetch ok=%b addr=%h stable=%b expected addr=%h stable=1", ok, a, st, exp_addr);
        end
        // Stall two EXEC cycles with a branch request that must be ignored.
        for (int i = 0; i < 2; i++) begin
            imem_ack = 1'b1;
            exec_step(2'b01, 32'h0000_0999, 1'b1);
            imem_ack = 1'b0;
            checks++;
            if (instr_valid !== 1'b1 || pc !== exp_addr || instr !== (exp_addr ^ KEY) || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d vld=%b pc=%h instr=%h req=%b expected pc=%h instr=%h", i, instr_valid, pc, instr, imem_req, exp_addr, exp_addr ^ KEY);
            end
        end
        exec_step(2'b00, 32'h0, 1'b0);
        exp_q.push_back(32'h0000_0010);
        run_fetch(0, a, st, ok);
        exp_addr = exp_q.pop_front();
        checks++;
        if (!ok || a !== exp_addr) begin
            errors++;
            $display("FAIL after_stall ok=%b addr=%h expected=%h", ok, a, exp_addr);
        end
    endtask

    task automatic test_branch();
        logic [31:0] a;
        logic        st, ok;
        exec_step(2'b01, 32'h0000_0040, 1'b0);
        exp_q.push_back(32'h0000_0040);
        run_fetch(1, a, st, ok);
        exp_addr = exp_q.pop_front();
        checks++;
        if (!ok || a !== exp_addr) begin
            errors++;
            $display("FAIL branch_to_40 ok=%b addr=%h expected=%h", ok, a, exp_addr);
        end
        exec_step(2'b01, 32'h0000_1237, 1'b0);
        exp_q.push_back(32'h0000_1234);
        checks++;
        if (pc_plus4 !== 32'h0000_1238) begin
            errors++;
            $display("FAIL branch_pc_plus4 got=%h expected=%h", pc_plus4, 32'h0000_1238);
        end
        run_fetch(0, a, st, ok);
        exp_addr = exp_q.pop_front();
        checks++;
        if (!ok || a !== exp_addr) begin
            errors++;
            $display("FAIL branch_align ok=%b addr=%h expected=%h", ok, a, exp_addr);
        end
    endtask

    task automatic test_exception();
        logic [31:0] a;
        logic        st, ok;
        exec_step(2'b01, 32'h0000_0100, 1'b0);
        run_fetch(0, a, st, ok);
        exec_step(2'b11, 32'h0, 1'b0);
        exp_q.push_back(EXC_VECTOR);
        checks++;
        if (epc !== 32'h0000_0100) begin
            errors++;
            $display("FAIL exc_epc got=%h expected=%h", epc, 32'h0000_0100);
        end
        run_fetch(0, a, st, ok);
        exp_addr = exp_q.pop_front();
        checks++;
        if (!ok || a !== exp_addr) begin
            errors++;
            $display("FAIL exc_vector ok=%b addr=%h expected=%h", ok, a, exp_addr);
        end
        exec_step(2'b00, 32'h0, 1'b0);
        run_fetch(0, a, st, ok);
        exec_step(2'b10, 32'h0, 1'b0);
        exp_q.push_back(32'h0000_0100);
        run_fetch(0, a, st, ok);
        exp_addr = exp_q.pop_front();
        checks++;
        if (!ok || a !== exp_addr || epc !== 32'h0000_0100) begin
            errors++;
            $display("FAIL eret ok=%b addr=%h epc=%h expected addr=%h epc=%h", ok, a, epc, exp_addr, 32'h0000_0100);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] a;
        logic        st, ok;
        exec_step(2'b01, 32'hFFFF_FFFC, 1'b0);
        run_fetch(0, a, st, ok);
        checks++;
        if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0000_0000) begin
            errors++;
            $display("FAIL wrap_plus4 pc=%h pc4=%h expected pc=FFFFFFFC pc4=00000000", pc, pc_plus4);
        end
        exec_step(2'b00, 32'h0, 1'b0);
        exp_q.push_back(32'h0000_0000);
        run_fetch(0, a, st, ok);
        exp_addr = exp_q.pop_front();
        checks++;
        if (!ok || a !== exp_addr) begin
            errors++;
            $display("FAIL wrap_fetch ok=%b addr=%h expected=%h", ok, a, exp_addr);
        end
    endtask

    task automatic test_reset_mid_fetch();
        exec_step(2'b01, 32'h0000_0200, 1'b0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0200) begin
            errors++;
            $display("FAIL pre_reset_fetch req=%b addr=%h expected req=1 addr=00000200", imem_req, imem_addr);
        end
        imem_ack = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (instr !== 32'h0 || pc !== RESET_PC || imem_req !== 1'b0 || epc !== 32'h0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset instr=%h pc=%h req=%b epc=%h vld=%b", instr, pc, imem_req, epc, instr_valid);
        end
        tick();
        imem_ack = 1'b0;
        rst_n    = 1'b1;
        checks++;
        if (imem_req !== 1'b0 || instr !== 32'h0) begin
            errors++;
            $display("FAIL post_reset_idle req=%b instr=%h expected req=0 instr=0", imem_req, instr);
        end
        exp_q.push_back(RESET_PC);
        tick();
        exp_addr = exp_q.pop_front();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
            errors++;
            $display("FAIL post_reset_fetch req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, exp_addr);
        end
    endtask

    initial begin
        test_reset();
        test_wait_stall();
        test_branch();
        test_exception();
        test_wrap();
        test_reset_mid_fetch();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover size=%0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
